// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bundle: push side, pop side, flush and occupancy status.
// Handshake: a transfer happens on a rising edge where valid && ready; ready and valid are
// driven from registered state only, and the producer holds its entry until it is accepted.
interface fetch_queue_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_instruction;
    logic [DATA_WIDTH-1:0]  in_program_counter;
    logic                   in_branch_taken_prediction;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_instruction;
    logic [DATA_WIDTH-1:0]  out_program_counter;
    logic                   out_branch_taken_prediction;
    logic [COUNT_WIDTH-1:0] count;
    logic                   almost_full;

    modport master (
        output flush, in_valid, in_instruction, in_program_counter, in_branch_taken_prediction,
        output out_ready,
        input  in_ready, out_valid, out_instruction, out_program_counter,
        input  out_branch_taken_prediction, count, almost_full
    );

    modport slave (
        input  flush, in_valid, in_instruction, in_program_counter, in_branch_taken_prediction,
        input  out_ready,
        output in_ready, out_valid, out_instruction, out_program_counter,
        output out_branch_taken_prediction, count, almost_full
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry circular buffer with
// first-word-fall-through head, single-cycle flush, occupancy count and almost_full.
module fetch_queue #(
    parameter int DATA_WIDTH        = 32,
    parameter int DEPTH             = 4,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1,
    parameter int COUNT_WIDTH       = $clog2(DEPTH + 1)
) (
    input logic         clk,
    input logic         reset_n,
    fetch_queue_if.slave q
);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] AF_COUNT   = COUNT_WIDTH'(ALMOST_FULL_LEVEL);
    localparam logic [PTR_WIDTH-1:0]   LAST_PTR   = PTR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0]  NOP_WORD   = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0]  instr_mem [DEPTH];
    logic [DATA_WIDTH-1:0]  pc_mem    [DEPTH];
    logic                   pred_mem  [DEPTH];

    logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [COUNT_WIDTH-1:0] count_q, count_next;
    logic                   almost_full_q;
    logic                   not_full, not_empty;
    logic                   push, pop;

    assign not_full  = (count_q != FULL_COUNT);
    assign not_empty = (count_q != '0);
    assign push      = q.in_valid && not_full && !q.flush;
    assign pop       = q.out_ready && not_empty && !q.flush;

    always_comb begin
        count_next = count_q;
        if (q.flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count_q + COUNT_WIDTH'(1);
        else if (pop && !push)
            count_next = count_q - COUNT_WIDTH'(1);
    end

    // Pointers wrap by explicit compare so non-power-of-two depths stay dense.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            count_q       <= count_next;
            almost_full_q <= (count_next >= AF_COUNT);
            if (q.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_WIDTH'(1);
                if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= q.in_instruction;
            pc_mem[wr_ptr]    <= q.in_program_counter;
            pred_mem[wr_ptr]  <= q.in_branch_taken_prediction;
        end
    end

    assign q.in_ready    = not_full;
    assign q.out_valid   = not_empty;
    assign q.count       = count_q;
    assign q.almost_full = almost_full_q;

    // An empty queue presents a NOP so decode never sees stale storage.
    assign q.out_instruction             = not_empty ? instr_mem[rd_ptr] : NOP_WORD;
    assign q.out_program_counter         = not_empty ? pc_mem[rd_ptr]    : '0;
    assign q.out_branch_taken_prediction = not_empty ? pred_mem[rd_ptr]  : 1'b0;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic on DEPTH=4 and DEPTH=3
// instances, checked each cycle against a queue-based reference model.
module tb_fetch_queue;
    typedef logic [64:0] entry_t;  // {prediction, pc, instruction}
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    int     n_checks = 0;
    int     n_fail = 0;
    entry_t exp_q[$];

    always #5 clk = ~clk;

    fetch_queue_if #(.DATA_WIDTH(32), .DEPTH(4)) f4 ();
    fetch_queue_if #(.DATA_WIDTH(32), .DEPTH(3)) f3 ();

    fetch_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut4 (.clk(clk), .reset_n(reset_n), .q(f4.slave));
    fetch_queue #(.DATA_WIDTH(32), .DEPTH(3)) dut3 (.clk(clk), .reset_n(reset_n), .q(f3.slave));

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    function automatic entry_t mk(input logic pred, input logic [31:0] pc, input logic [31:0] instr);
        return {pred, pc, instr};
    endfunction

    function automatic entry_t rnd_entry();
        return {1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic check(input string tag, input entry_t got, input entry_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        f4.flush = 0; f4.in_valid = 0; f4.out_ready = 0;
        f4.in_instruction = '0; f4.in_program_counter = '0; f4.in_branch_taken_prediction = 0;
        f3.flush = 0; f3.in_valid = 0; f3.out_ready = 0;
        f3.in_instruction = '0; f3.in_program_counter = '0; f3.in_branch_taken_prediction = 0;
    endtask

    // Compares every DUT output with what the model says the queue holds right now.
    task automatic check_now(input bit d3, input string tag);
        int     depth = d3 ? 3 : 4;
        int     size = exp_q.size();
        int     cnt;
        logic   ir, ov, af;
        entry_t head;
        if (d3) begin
            cnt = int'(f3.count); ir = f3.in_ready; ov = f3.out_valid; af = f3.almost_full;
            head = {f3.out_branch_taken_prediction, f3.out_program_counter, f3.out_instruction};
        end else begin
            cnt = int'(f4.count); ir = f4.in_ready; ov = f4.out_valid; af = f4.almost_full;
            head = {f4.out_branch_taken_prediction, f4.out_program_counter, f4.out_instruction};
        end
        check({tag, " count"}, entry_t'(cnt), entry_t'(size));
        check({tag, " in_ready"}, entry_t'(ir), entry_t'(size < depth));
        check({tag, " out_valid"}, entry_t'(ov), entry_t'(size > 0));
        check({tag, " almost_full"}, entry_t'(af), entry_t'(size >= depth - 1));
        check({tag, " head"}, head, (size > 0) ? exp_q[0] : mk(1'b0, 32'h0, NOP));
    endtask

    // Drives one cycle, checks pre-edge state, updates the model, then steps past the edge.
    task automatic cycle(input bit d3, input string tag, input logic v, input entry_t e,
                         input logic ordy, input logic fl);
        int   depth = d3 ? 3 : 4;
        logic do_push, do_pop;
        if (d3) begin
            f3.in_valid = v; f3.out_ready = ordy; f3.flush = fl;
            {f3.in_branch_taken_prediction, f3.in_program_counter, f3.in_instruction} = e;
        end else begin
            f4.in_valid = v; f4.out_ready = ordy; f4.flush = fl;
            {f4.in_branch_taken_prediction, f4.in_program_counter, f4.in_instruction} = e;
        end
        check_now(d3, tag);
        do_push = v && (exp_q.size() < depth) && !fl;
        do_pop  = ordy && (exp_q.size() > 0) && !fl;
        if (fl) exp_q.delete();
        else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        // Reset held with fetch presenting an entry.
        f4.in_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        check_now(0, "reset");
        check("reset instr", entry_t'(f4.out_instruction), entry_t'(NOP));
        reset_n = 1;
        cycle(0, "rst_push", 1, mk(1'b0, 32'h100, 32'h0000_00aa), 0, 0);
        check_now(0, "after_push");
        check("first pc", entry_t'(f4.out_program_counter), entry_t'(32'h100));

        // Reset mid-operation clears contents without waiting for a clock edge.
        cycle(0, "pre_async", 1, mk(1'b1, 32'h104, 32'h0000_00bb), 0, 0);
        #2 reset_n = 0;
        #1;
        check("async count", entry_t'(f4.count), entry_t'(0));
        check("async out_valid", entry_t'(f4.out_valid), entry_t'(0));
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1;

        // Fill to DEPTH, refuse a fifth entry, then drain in order.
        for (int i = 0; i < 4; i++)
            cycle(0, "fill", 1, mk(1'(i), 32'(i * 4), 32'ha0 + 32'(i)), 0, 0);
        cycle(0, "fifth", 1, mk(1'b0, 32'h10, 32'ha4), 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, "drain", 0, '0, 1, 0);
        check_now(0, "drained");

        // Sustained push+pop at count 2.
        for (int i = 0; i < 2; i++) cycle(0, "pp_fill", 1, rnd_entry(), 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, "pp", 1, rnd_entry(), 1, 0);
        check("pp count", entry_t'(f4.count), entry_t'(2));

        // Full with pop: push refused this edge, accepted the next.
        for (int i = 0; i < 2; i++) cycle(0, "full_fill", 1, rnd_entry(), 0, 0);
        cycle(0, "full_pop", 1, mk(1'b1, 32'h300, 32'h33), 1, 0);
        check("full_pop count", entry_t'(f4.count), entry_t'(3));
        cycle(0, "full_push", 1, mk(1'b1, 32'h300, 32'h33), 0, 0);
        check("full_push count", entry_t'(f4.count), entry_t'(4));

        // Flush at count 3 with both handshakes active.
        cycle(0, "pre_flush", 0, '0, 1, 0);
        cycle(0, "flush", 1, mk(1'b1, 32'h400, 32'h44), 1, 1);
        check("flush count", entry_t'(f4.count), entry_t'(0));
        check("flush out_valid", entry_t'(f4.out_valid), entry_t'(0));
        check("flush in_ready", entry_t'(f4.in_ready), entry_t'(1));
        cycle(0, "post_flush", 1, mk(1'b0, 32'h200, 32'h55), 0, 0);
        check("post_flush pc", entry_t'(f4.out_program_counter), entry_t'(32'h200));

        // Random traffic on DEPTH=4.
        for (int i = 0; i < 30; i++)
            cycle(0, "rnd4", $urandom_range(0, 3) != 0, rnd_entry(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        cycle(0, "rnd4_end", 0, '0, 0, 1);
        check_now(0, "rnd4_empty");
        idle();

        // Random traffic on DEPTH=3 exercising the 2->0 pointer wrap.
        for (int i = 0; i < 40; i++) begin
            cycle(1, "rnd3", $urandom_range(0, 3) != 0, rnd_entry(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            check("rnd3 bound", entry_t'(f3.count <= 3), entry_t'(1));
        end
        check_now(1, "rnd3_end");
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
